// File: rtl/cdb_pkg.sv
// Shared defaults for the common-data-bus arbiter: bus widths, unit count
// and the reserved "no producer" tag value.
package cdb_pkg;

  localparam int CDB_N_REQ  = 3;
  localparam int CDB_DATA_W = 16;
  localparam int CDB_TAG_W  = 3;

  // Tag 0 marks a result with no producing reservation station.
  localparam int NO_TAG = 0;

endpackage : cdb_pkg

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational one-hot picker: the first eligible unit at or after start_i,
// ascending and wrapping from N-1 back to 0.
module rr_picker #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     elig_i,
  input  logic [PTR_W-1:0] start_i,
  output logic [N-1:0]     grant_o
);

  logic found;
  int   pos;

  // NOTE: every variable written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    pos     = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start_i) + k;
      if (pos >= N) pos = pos - N;
      // Constant-index compare keeps the select width-clean after unrolling.
      for (int i = 0; i < N; i++) begin
        if (!found && (i == pos) && elig_i[i]) begin
          grant_o[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule : rr_picker

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one registered broadcast per cycle from N_REQ units.
// Define CDB_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int N_REQ  = CDB_N_REQ,
  parameter int DATA_W = CDB_DATA_W,
  parameter int TAG_W  = CDB_TAG_W
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*TAG_W-1:0]    tag_in,
  input  logic [N_REQ*DATA_W-1:0]   data_in,
  input  logic                      cdb_hold,
  output logic [N_REQ-1:0]          grant,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [15:0]               bcast_count
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  elig;
  logic [PTR_W-1:0]  start_ptr;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;

  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [15:0]       bcast_count_q, bcast_count_d;

  // Reset and hold gate eligibility so grant is zero combinationally in both.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req[i] && (tag_in[i*TAG_W +: TAG_W] != TAG_W'(NO_TAG))
                && !cdb_hold && Resetn;
    end
  end

  rr_picker #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .elig_i  (elig),
    .start_i (start_ptr),
    .grant_o (grant)
  );

  always_comb begin
    win_tag  = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        win_tag  = tag_in[i*TAG_W +: TAG_W];
        win_data = data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    cdb_valid_d   = |grant;
    cdb_tag_d     = cdb_tag_q;
    cdb_data_d    = cdb_data_q;
    bcast_count_d = bcast_count_q;
    if (|grant) begin
      cdb_tag_d     = win_tag;
      cdb_data_d    = win_data;
      bcast_count_d = bcast_count_q + 16'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      cdb_valid_q   <= 1'b0;
      cdb_tag_q     <= '0;
      cdb_data_q    <= '0;
      bcast_count_q <= '0;
    end else begin
      cdb_valid_q   <= cdb_valid_d;
      cdb_tag_q     <= cdb_tag_d;
      cdb_data_q    <= cdb_data_d;
      bcast_count_q <= bcast_count_d;
    end
  end

`ifdef CDB_ARB_RR_EN
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) win_idx = PTR_W'(i);
    end
  end

  // Pointer moves one past the winner; it only moves on an actual grant.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|grant) begin
      rr_ptr_d = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end

  assign start_ptr = rr_ptr_q;
`else
  assign start_ptr = '0;
`endif

  assign cdb_valid   = cdb_valid_q;
  assign cdb_tag     = cdb_tag_q;
  assign cdb_data    = cdb_data_q;
  assign bcast_count = bcast_count_q;

endmodule : cdb_arbiter
